// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Register 0 is the hardwired zero register.
package regfile_pkg;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_RD   = 2;
  localparam int ZERO_REG     = 0;

  // Width of a counter able to hold 0..n-1 busy registers plus headroom.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-writeback tracking: issue sets, writeback clears,
// issue wins on a same-cycle collision. busy_cnt is the registered popcount.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                iss_en,
  input  logic [ADDR_W-1:0]   iss_addr,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic [ADDR_W:0]     busy_cnt
);
  logic [NUM_REGS-1:0] busy_d, busy_q;
  logic [ADDR_W:0]     cnt_d, cnt_q;

  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[wr_addr] = 1'b0;
    if (iss_en && iss_addr != ADDR_W'(ZERO_REG)) busy_d[iss_addr] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
    cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) cnt_d = cnt_d + (ADDR_W+1)'(busy_d[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: clocked writes, combinational reads with
// same-cycle write bypass, hardwired r0, and a writeback scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          busy_cnt
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_d, regs_q;
  logic [NUM_REGS-1:0]             busy;

  always_comb begin
    regs_d = regs_q;
    if (wr_en && wr_addr != ADDR_W'(ZERO_REG)) regs_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  // A writeback in flight this cycle is seen as both its data and not-busy;
  // everything reads 0 while reset is held, bypass included.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              live, hit;
    assign addr = rd_addr[k*ADDR_W +: ADDR_W];
    assign live = rst_n && (addr != ADDR_W'(ZERO_REG));
    assign hit  = wr_en && (wr_addr == addr);
    assign rd_data[k*DATA_W +: DATA_W] = !live ? '0 : (hit ? wr_data : regs_q[addr]);
    assign rd_busy[k] = live && busy[addr] && !hit;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp (16 regs, 4 read ports, 64-bit data): directed
// literal checks plus a per-cycle comparison against an array model.
module tb_regfile_mp;
  localparam int DW  = 64;
  localparam int NR  = 16;
  localparam int AW  = 4;
  localparam int NRD = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic [AW:0]       busy_cnt;

  int tests = 0;
  int fails = 0;
  bit cmp_on = 1'b0;

  regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  // Architectural model: contents and pending-writeback set.
  bit [DW-1:0] mem [NR];
  bit          mbusy [NR];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin
        mem[i]   <= '0;
        mbusy[i] <= 1'b0;
      end
    end else begin
      if (wr_en && wr_addr != 0) mem[wr_addr] <= wr_data;
      if (wr_en) mbusy[wr_addr] <= 1'b0;
      if (iss_en && iss_addr != 0) mbusy[iss_addr] <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pdata(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  always @(negedge clk) begin
    if (cmp_on) begin
      int cnt;
      cnt = 0;
      for (int i = 0; i < NR; i++) cnt += int'(mbusy[i]);
      chk("m_busy_cnt", DW'(busy_cnt), !rst_n ? '0 : DW'(cnt));
      for (int k = 0; k < NRD; k++) begin
        int      a;
        bit [DW-1:0] ed;
        bit      eb;
        a = int'(rd_addr[k*AW +: AW]);
        if (!rst_n || a == 0)              begin ed = '0;      eb = 1'b0; end
        else if (wr_en && wr_addr == a)    begin ed = wr_data; eb = 1'b0; end
        else                               begin ed = mem[a];  eb = mbusy[a]; end
        chk("m_rd_data", pdata(k), ed);
        chk("m_rd_busy", DW'(rd_busy[k]), DW'(eb));
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk); #1; endtask
  task automatic idle();
    wr_en = 0; iss_en = 0; wr_addr = 0; iss_addr = 0; wr_data = '0;
  endtask
  task automatic set_rd(input int k, input int a);
    rd_addr[k*AW +: AW] = AW'(a);
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0; idle();
    repeat (2) tick();
    cmp_on = 1'b1;
    mid();
    chk("rst_cnt", DW'(busy_cnt), 0);
    chk("rst_data", pdata(0), 0);
    rst_n = 1'b1;

    // r0 is never written nor marked busy
    tick();
    wr_en = 1; wr_addr = 0; wr_data = '1; iss_en = 1; iss_addr = 0;
    mid();
    chk("zero_data", pdata(0), 0);
    chk("zero_busy", DW'(rd_busy[0]), 0);
    tick(); idle();
    mid();
    chk("zero_cnt", DW'(busy_cnt), 0);
    chk("zero_data2", pdata(0), 0);

    // bypass then storage
    set_rd(0, 7); set_rd(1, 7);
    wr_en = 1; wr_addr = 7; wr_data = 64'h1234_5678;
    mid();
    chk("byp_p0", pdata(0), 64'h1234_5678);
    chk("byp_p1", pdata(1), 64'h1234_5678);
    tick(); idle();
    mid();
    chk("store_p0", pdata(0), 64'h1234_5678);
    chk("store_busy", DW'(rd_busy[0]), 0);

    // issue r3, writeback three cycles later
    set_rd(2, 3);
    iss_en = 1; iss_addr = 3;
    tick(); idle();
    mid();
    chk("sb_busy", DW'(rd_busy[2]), 1);
    chk("sb_cnt1", DW'(busy_cnt), 1);
    tick(); tick();
    wr_en = 1; wr_addr = 3; wr_data = 64'hA5;
    mid();
    chk("sb_wb_busy", DW'(rd_busy[2]), 0);
    chk("sb_wb_data", pdata(2), 64'hA5);
    chk("sb_wb_cnt", DW'(busy_cnt), 1);
    tick(); idle();
    mid();
    chk("sb_cnt0", DW'(busy_cnt), 0);
    chk("sb_data", pdata(2), 64'hA5);

    // issue and writeback r9 together: issue wins
    set_rd(3, 9);
    iss_en = 1; iss_addr = 9; wr_en = 1; wr_addr = 9; wr_data = 64'h55;
    mid();
    chk("sim_byp", pdata(3), 64'h55);
    tick(); idle();
    mid();
    chk("sim_data", pdata(3), 64'h55);
    chk("sim_busy", DW'(rd_busy[3]), 1);
    chk("sim_cnt", DW'(busy_cnt), 1);
    // WAW reissue keeps one busy bit, first writeback clears it
    iss_en = 1; iss_addr = 9;
    tick(); idle();
    mid();
    chk("waw_cnt", DW'(busy_cnt), 1);
    wr_en = 1; wr_addr = 9; wr_data = 64'h66;
    mid();
    chk("waw_wb_busy", DW'(rd_busy[3]), 0);
    tick(); idle();
    mid();
    chk("waw_cnt0", DW'(busy_cnt), 0);
    chk("waw_data", pdata(3), 64'h66);

    // reset mid-cycle wipes data, busy and a bypass in flight
    wr_en = 1; wr_addr = 5; wr_data = 64'hDEAD_BEEF; iss_en = 1; iss_addr = 4;
    set_rd(0, 5); set_rd(1, 4);
    tick(); idle();
    mid();
    chk("pre_rst_data", pdata(0), 64'hDEAD_BEEF);
    chk("pre_rst_cnt", DW'(busy_cnt), 1);
    chk("pre_rst_busy", DW'(rd_busy[1]), 1);
    wr_en = 1; wr_addr = 5; wr_data = 64'h1111;
    #1 rst_n = 1'b0;
    #1;
    chk("in_rst_data", pdata(0), 0);
    chk("in_rst_cnt", DW'(busy_cnt), 0);
    chk("in_rst_busy", DW'(rd_busy[1]), 0);
    tick(); idle();
    mid();
    rst_n = 1'b1;
    mid();
    chk("post_rst_data", pdata(0), 0);
    chk("post_rst_cnt", DW'(busy_cnt), 0);

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 10000; c++) begin
      tick();
      iss_en   = ($urandom_range(0, 2) == 0);
      iss_addr = AW'($urandom);
      wr_en    = ($urandom_range(0, 1) == 0);
      wr_addr  = AW'($urandom);
      wr_data  = {$urandom, $urandom};
      rd_addr  = (NRD*AW)'($urandom);
    end
    tick(); idle();
    mid();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
